tx_link_ctrl: RTL and testbench
===============================

TX_LINK_CTRL -- requirements
Module: tx_link_ctrl

Interface
REQ-001 F, default 4: octets per frame (1..256).
REQ-002 K, default 8: frames per multiframe (1..32); F*K SHALL be between 17 and 1024.
REQ-003 RESYNC_CYC, default 29: consecutive low SYNC~ cycles that trigger resync (5*F+9 for F=4).
REQ-004 clk  in  1  character clock; single clock domain.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 i_link_en  in  1  link enable; 0 forces IDLE.
REQ-007 i_sync_n  in  1  SYNC~ from receiver, active-low, already synchronous to clk.
REQ-008 o_link_mux  out  3  link layer stream select: 0 user data, 1 continuous K, 2 ILA.
REQ-009 o_state  out  2  state: 0 IDLE, 1 CGS, 2 ILAS, 3 DATA.
REQ-010 o_octet_cnt  out  8  octet index in frame, 0..F-1.
REQ-011 o_frame_cnt  out  5  frame index in multiframe, 0..K-1.
REQ-012 o_lmfc  out  1  high when o_octet_cnt==0 and o_frame_cnt==0.
REQ-013 o_ila_mf_idx  out  2  ILAS multiframe index, 0..3.
REQ-014 o_user_rdy  out  1  high only in DATA; user data is accepted.
REQ-015 o_resync_cnt  out  8  saturating count of resync events.

Function
REQ-016 All outputs SHALL be registered or decoded from registers only; no combinational path from inputs to outputs.
REQ-017 o_octet_cnt SHALL increment every cycle and wrap F-1->0; o_frame_cnt SHALL increment on each octet wrap and wrap K-1->0. Both counters run freely regardless of state.
REQ-018 o_link_mux SHALL be a pure decode of state: IDLE->1, CGS->1, ILAS->2, DATA->0.
REQ-019 IDLE->CGS on the next edge when i_link_en=1.
REQ-020 CGS->ILAS SHALL occur only at the edge where o_octet_cnt==F-1, o_frame_cnt==K-1 and i_sync_n==1 are all sampled. The first ILAS cycle therefore has o_lmfc=1.
REQ-021 ILAS SHALL last exactly 4*F*K cycles. o_ila_mf_idx SHALL be 0 on ILAS entry and SHALL increment at each multiframe wrap. ILAS->DATA occurs at the edge ending the last octet of multiframe 3.
REQ-022 o_ila_mf_idx SHALL return to 0 on any exit from ILAS.
REQ-023 A low-run counter SHALL count consecutive cycles with i_sync_n==0, saturating at RESYNC_CYC. Any cycle with i_sync_n==1 SHALL clear it. The counter is cleared while in IDLE or CGS.
REQ-024 In ILAS or DATA, when i_sync_n is sampled low and the low-run count reaches RESYNC_CYC on that sample, the next state SHALL be CGS. o_resync_cnt SHALL increment once per such event and saturate at 255.
REQ-025 In CGS, a low i_sync_n SHALL hold CGS with no count. A high i_sync_n away from the LMFC boundary SHALL also hold CGS.
REQ-026 i_link_en==0 SHALL move any state to IDLE on the next edge. This has priority over resync and all other transitions; o_resync_cnt does not increment.
REQ-027 Undefined state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-028 On the edge where rst=1 is sampled: state IDLE, o_link_mux=1, o_octet_cnt=0, o_frame_cnt=0, o_lmfc=1, o_ila_mf_idx=0, o_user_rdy=0, o_resync_cnt=0, low-run counter 0.
REQ-029 Reset asserted in any state, including mid-ILAS or mid-resync count, SHALL apply REQ-028 in full on that edge. No output SHALL depend on pre-reset history.

Verification (F=4, K=8; multiframe 32 cycles, ILAS 128 cycles)
REQ-030 rst high 3 cycles -> after the first sampled edge: state 0, mux 1, octet 0, frame 0, lmfc 1, user_rdy 0, resync_cnt 0.
REQ-031 link_en=1 with sync_n low 100 cycles, then high -> mux stays 1 until the first edge at octet 3 / frame 7 with sync_n high. Then mux 2 for exactly 128 cycles, with mf_idx 0,1,2,3 for 32 cycles each. Then mux 0 and user_rdy 1, with the first DATA cycle at lmfc=1.
REQ-032 In CGS, sync_n rises at octet 1 / frame 7 -> ILAS starts 3 cycles later, at octet 0 / frame 0. sync_n rising at octet 3 / frame 7 -> ILAS starts on the next cycle.
REQ-033 In DATA, sync_n low 28 cycles then high -> state stays DATA and resync_cnt 0. sync_n low 29 cycles -> CGS on the next cycle, mux 1, user_rdy 0, resync_cnt 1.
REQ-034 link_en dropped during ILAS multiframe 2 while sync_n is also low 29 cycles -> IDLE on the next edge, mf_idx 0, resync_cnt unchanged.
REQ-035 300 forced resync events -> resync_cnt reads 255 and stays 255.

Source files
------------

// File: rtl/tx_link_ctrl.sv
// Transmit link-layer controller: free-running frame/multiframe (LMFC)
// counters, CGS/ILAS/DATA sequencing against SYNC~, and resync detection.
module tx_link_ctrl #(
    parameter int unsigned F          = 4,
    parameter int unsigned K          = 8,
    parameter int unsigned RESYNC_CYC = 29
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_link_en,
    input  logic       i_sync_n,
    output logic [2:0] o_link_mux,
    output logic [1:0] o_state,
    output logic [7:0] o_octet_cnt,
    output logic [4:0] o_frame_cnt,
    output logic       o_lmfc,
    output logic [1:0] o_ila_mf_idx,
    output logic       o_user_rdy,
    output logic [7:0] o_resync_cnt
);

    localparam int unsigned OCT_W = 8;
    localparam int unsigned FRM_W = 5;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned MUX_W = 3;
    localparam int unsigned MFI_W = 2;
    localparam int unsigned RUN_W = $clog2(RESYNC_CYC + 1);

    localparam logic [OCT_W-1:0] OCT_LAST = OCT_W'(F - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(K - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(RESYNC_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(255);
    localparam logic [MFI_W-1:0] MF_LAST  = MFI_W'(3);

    localparam logic [MUX_W-1:0] MUX_DATA = MUX_W'(0);
    localparam logic [MUX_W-1:0] MUX_K    = MUX_W'(1);
    localparam logic [MUX_W-1:0] MUX_ILA  = MUX_W'(2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CGS  = 2'd1,
        ST_ILAS = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [OCT_W-1:0] octet_q, octet_d;
    logic [FRM_W-1:0] frame_q, frame_d;
    logic [MFI_W-1:0] mf_idx_q, mf_idx_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] resync_q, resync_d;
    logic [MUX_W-1:0] mux_q, mux_d;
    logic             rdy_q, rdy_d;
    logic             lmfc_q, lmfc_d;

    logic             octet_end;
    logic             mf_end;
    logic [RUN_W-1:0] run_inc;
    logic             run_hit;
    logic [CNT_W-1:0] resync_inc;

    // Boundary detection and saturating increments shared by the FSM
    assign octet_end  = (octet_q == OCT_LAST);
    assign mf_end     = octet_end && (frame_q == FRM_LAST);
    assign run_inc    = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
    assign run_hit    = !i_sync_n && (run_inc == RUN_MAX);
    assign resync_inc = (resync_q == CNT_MAX) ? resync_q : resync_q + CNT_W'(1);

    // Free-running octet/frame counters, independent of link state
    always_comb begin
        octet_d = octet_q + OCT_W'(1);
        frame_d = frame_q;
        if (octet_end) begin
            octet_d = '0;
            frame_d = (frame_q == FRM_LAST) ? '0 : frame_q + FRM_W'(1);
        end
    end

    // Link FSM next state, ILAS multiframe index, SYNC~ low-run and resync count
    always_comb begin
        state_d  = state_q;
        mf_idx_d = mf_idx_q;
        run_d    = '0;
        resync_d = resync_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_CGS;
            end
            ST_CGS: begin
                // Leave CGS only on an LMFC boundary so ILAS starts multiframe-aligned
                if (i_sync_n && mf_end) begin
                    state_d = ST_ILAS;
                end
            end
            ST_ILAS: begin
                run_d = i_sync_n ? '0 : run_inc;
                if (run_hit) begin
                    state_d  = ST_CGS;
                    resync_d = resync_inc;
                end else if (mf_end) begin
                    if (mf_idx_q == MF_LAST) begin
                        state_d = ST_DATA;
                    end else begin
                        mf_idx_d = mf_idx_q + MFI_W'(1);
                    end
                end
            end
            ST_DATA: begin
                run_d = i_sync_n ? '0 : run_inc;
                if (run_hit) begin
                    state_d  = ST_CGS;
                    resync_d = resync_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Link disable overrides everything, including a coincident resync
        if (!i_link_en) begin
            state_d  = ST_IDLE;
            resync_d = resync_q;
            run_d    = '0;
        end
        if (state_d != ST_ILAS) begin
            mf_idx_d = '0;
        end
    end

    // Output decode of the next state/counters so outputs come straight from flops
    always_comb begin
        mux_d  = MUX_K;
        rdy_d  = 1'b0;
        lmfc_d = (octet_d == '0) && (frame_d == '0);
        case (state_d)
            ST_ILAS: mux_d = MUX_ILA;
            ST_DATA: begin
                mux_d = MUX_DATA;
                rdy_d = 1'b1;
            end
            default: mux_d = MUX_K;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            octet_q  <= '0;
            frame_q  <= '0;
            mf_idx_q <= '0;
            run_q    <= '0;
            resync_q <= '0;
            mux_q    <= MUX_K;
            rdy_q    <= 1'b0;
            lmfc_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            octet_q  <= octet_d;
            frame_q  <= frame_d;
            mf_idx_q <= mf_idx_d;
            run_q    <= run_d;
            resync_q <= resync_d;
            mux_q    <= mux_d;
            rdy_q    <= rdy_d;
            lmfc_q   <= lmfc_d;
        end
    end

    assign o_state      = state_q;
    assign o_link_mux   = mux_q;
    assign o_octet_cnt  = octet_q;
    assign o_frame_cnt  = frame_q;
    assign o_lmfc       = lmfc_q;
    assign o_ila_mf_idx = mf_idx_q;
    assign o_user_rdy   = rdy_q;
    assign o_resync_cnt = resync_q;

endmodule

// File: tb/tb_tx_link_ctrl.sv
// Bench for tx_link_ctrl: directed link scenarios plus randomized SYNC~/enable
// traffic, all checked against a cycle-count based reference model.
module tb_tx_link_ctrl;

    localparam int F          = 4;
    localparam int K          = 8;
    localparam int RESYNC     = 29;
    localparam int MF         = F * K;
    localparam int ILA_LEN    = 4 * MF;

    logic       clk = 1'b0;
    logic       rst;
    logic       link_en;
    logic       sync_n;
    logic [2:0] link_mux;
    logic [1:0] state;
    logic [7:0] octet_cnt;
    logic [4:0] frame_cnt;
    logic       lmfc;
    logic [1:0] mf_idx;
    logic       user_rdy;
    logic [7:0] resync_cnt;

    logic [29:0] act;
    logic [29:0] reset_vec;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: state code, position in multiframe, cycles spent in ILAS,
    // current SYNC~ low run and resync event count
    int m_st  = 0;
    int m_pos = 0;
    int m_ila = 0;
    int m_run = 0;
    int m_rs  = 0;

    tx_link_ctrl #(.F(F), .K(K), .RESYNC_CYC(RESYNC)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_link_en    (link_en),
        .i_sync_n     (sync_n),
        .o_link_mux   (link_mux),
        .o_state      (state),
        .o_octet_cnt  (octet_cnt),
        .o_frame_cnt  (frame_cnt),
        .o_lmfc       (lmfc),
        .o_ila_mf_idx (mf_idx),
        .o_user_rdy   (user_rdy),
        .o_resync_cnt (resync_cnt)
    );

    always #5 clk = ~clk;

    assign act       = {state, link_mux, octet_cnt, frame_cnt, lmfc, mf_idx, user_rdy, resync_cnt};
    assign reset_vec = {2'd0, 3'd1, 8'd0, 5'd0, 1'b1, 2'd0, 1'b0, 8'd0};

    // Expected output vector derived from the model's current position and state
    function automatic logic [29:0] model_vec();
        logic [2:0] mux;
        logic [1:0] mf;
        case (m_st)
            2:       mux = 3'd2;
            3:       mux = 3'd0;
            default: mux = 3'd1;
        endcase
        mf = (m_st == 2) ? 2'(m_ila / MF) : 2'd0;
        return {2'(m_st), mux, 8'(m_pos % F), 5'(m_pos / F), (m_pos == 0), mf, (m_st == 3), 8'(m_rs)};
    endfunction

    // Advance the model on the currently driven inputs, then clock the DUT
    task automatic tick();
        int  nst;
        int  low;
        bit  resync;
        if (rst) begin
            m_st = 0; m_pos = 0; m_ila = 0; m_run = 0; m_rs = 0;
        end else begin
            nst = m_st;
            low = 0;
            if (m_st >= 2 && !sync_n) begin
                low = (m_run + 1 > RESYNC) ? RESYNC : m_run + 1;
            end
            resync = (m_st >= 2) && !sync_n && (low == RESYNC);
            if (!link_en) begin
                nst = 0;
            end else if (m_st == 0) begin
                nst = 1;
            end else if (m_st == 1) begin
                if (sync_n && m_pos == MF - 1) begin
                    nst = 2;
                    m_ila = 0;
                end
            end else if (resync) begin
                nst = 1;
                if (m_rs < 255) m_rs++;
            end else if (m_st == 2) begin
                if (m_ila == ILA_LEN - 1) nst = 3;
                else m_ila++;
            end
            m_run = low;
            m_st  = nst;
            m_pos = (m_pos + 1) % MF;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Reset values after each sampled reset edge
    task automatic test_reset();
        rst = 1'b1;
        link_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sync_n = 1'($urandom_range(0, 1));
            tick();
            vectors++;
            if (act !== reset_vec) begin
                miscompares++;
                $display("FAIL reset_values cyc%0d: dut=%h required=%h", i, act, reset_vec);
            end
            vectors++;
            if (act !== model_vec()) begin
                miscompares++;
                $display("FAIL reset_model cyc%0d: dut=%h model=%h", i, act, model_vec());
            end
        end
        rst = 1'b0;
    endtask

    // CGS with long SYNC~ low, LMFC-aligned ILAS of 4 multiframes, then DATA
    task automatic test_bringup();
        int n;
        link_en = 1'b1;
        sync_n  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            vectors++;
            if (link_mux !== 3'd1 || act !== model_vec()) begin
                miscompares++;
                $display("FAIL bringup_cgs cyc%0d: dut=%h model=%h", i, act, model_vec());
            end
        end
        sync_n = 1'b1;
        n = 0;
        while (state !== 2'd2 && n < 64) begin
            tick();
            n++;
            vectors++;
            if (act !== model_vec()) begin
                miscompares++;
                $display("FAIL bringup_wait: dut=%h model=%h", act, model_vec());
            end
        end
        vectors++;
        if (state !== 2'd2 || lmfc !== 1'b1 || link_mux !== 3'd2) begin
            miscompares++;
            $display("FAIL bringup_ilas_entry: state=%0d lmfc=%b mux=%0d required 2/1/2", state, lmfc, link_mux);
        end
        n = 0;
        while (link_mux === 3'd2 && n < 200) begin
            vectors++;
            if (mf_idx !== 2'(n / MF)) begin
                miscompares++;
                $display("FAIL bringup_mf_idx ilas_cyc%0d: dut=%0d required=%0d", n, mf_idx, n / MF);
            end
            tick();
            n++;
        end
        vectors++;
        if (n != ILA_LEN) begin
            miscompares++;
            $display("FAIL bringup_ilas_len: dut=%0d required=%0d", n, ILA_LEN);
        end
        vectors++;
        if (state !== 2'd3 || user_rdy !== 1'b1 || link_mux !== 3'd0 || lmfc !== 1'b1) begin
            miscompares++;
            $display("FAIL bringup_data_entry: state=%0d rdy=%b mux=%0d lmfc=%b required 3/1/0/1", state, user_rdy, link_mux, lmfc);
        end
    endtask

    // SYNC~ release position within the last frame sets the ILAS start delay
    task automatic test_cgs_align();
        int n;
        logic [7:0] rel_oct;
        int expect_n;
        for (int pass = 0; pass < 2; pass++) begin
            rel_oct  = (pass == 0) ? 8'd1 : 8'd3;
            expect_n = (pass == 0) ? 3 : 1;
            link_en = 1'b0;
            tick();
            vectors++;
            if (state !== 2'd0 || act !== model_vec()) begin
                miscompares++;
                $display("FAIL align_idle: dut=%h model=%h", act, model_vec());
            end
            link_en = 1'b1;
            sync_n  = 1'b0;
            tick();
            n = 0;
            while (!(octet_cnt === rel_oct && frame_cnt === 5'd7) && n < 64) begin
                tick();
                n++;
            end
            vectors++;
            if (state !== 2'd1 || act !== model_vec()) begin
                miscompares++;
                $display("FAIL align_cgs: dut=%h model=%h", act, model_vec());
            end
            sync_n = 1'b1;
            n = 0;
            while (state !== 2'd2 && n < 64) begin
                tick();
                n++;
            end
            vectors++;
            if (n != expect_n || octet_cnt !== 8'd0 || frame_cnt !== 5'd0) begin
                miscompares++;
                $display("FAIL align_delay_oct%0d: cycles=%0d octet=%0d frame=%0d required %0d/0/0", rel_oct, n, octet_cnt, frame_cnt, expect_n);
            end
        end
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget);
        int n = 0;
        while (state !== st && n < budget) begin
            tick();
            n++;
        end
        vectors++;
        if (state !== st) begin
            miscompares++;
            $display("FAIL wait_state: state=%0d required=%0d", state, st);
        end
    endtask

    // Resync threshold: 28 low cycles tolerated, 29 forces CGS
    task automatic test_resync();
        do_reset();
        link_en = 1'b1;
        sync_n  = 1'b1;
        wait_state(2'd3, 300);
        sync_n = 1'b0;
        for (int i = 0; i < 28; i++) tick();
        sync_n = 1'b1;
        tick();
        vectors++;
        if (state !== 2'd3 || resync_cnt !== 8'd0 || act !== model_vec()) begin
            miscompares++;
            $display("FAIL resync_28: state=%0d resync=%0d required 3/0", state, resync_cnt);
        end
        sync_n = 1'b0;
        for (int i = 0; i < 29; i++) begin
            tick();
            vectors++;
            if (act !== model_vec()) begin
                miscompares++;
                $display("FAIL resync_model cyc%0d: dut=%h model=%h", i, act, model_vec());
            end
        end
        vectors++;
        if (state !== 2'd1 || link_mux !== 3'd1 || user_rdy !== 1'b0 || resync_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL resync_29: state=%0d mux=%0d rdy=%b resync=%0d required 1/1/0/1", state, link_mux, user_rdy, resync_cnt);
        end
    endtask

    // Link disable coinciding with a resync in ILAS multiframe 2
    task automatic test_link_drop();
        do_reset();
        link_en = 1'b1;
        sync_n  = 1'b1;
        wait_state(2'd2, 64);
        for (int n = 0; n < 200 && mf_idx !== 2'd2; n++) tick();
        sync_n = 1'b0;
        for (int i = 0; i < 28; i++) tick();
        vectors++;
        if (state !== 2'd2 || mf_idx !== 2'd2) begin
            miscompares++;
            $display("FAIL drop_pre: state=%0d mf_idx=%0d required 2/2", state, mf_idx);
        end
        link_en = 1'b0;
        tick();
        vectors++;
        if (state !== 2'd0 || mf_idx !== 2'd0 || resync_cnt !== 8'd0 || act !== model_vec()) begin
            miscompares++;
            $display("FAIL drop_idle: state=%0d mf_idx=%0d resync=%0d required 0/0/0", state, mf_idx, resync_cnt);
        end
        link_en = 1'b1;
        sync_n  = 1'b1;
    endtask

    // Reset in mid-ILAS with a partial low run must leave no history behind
    task automatic test_reset_mid();
        do_reset();
        link_en = 1'b1;
        sync_n  = 1'b1;
        wait_state(2'd2, 64);
        for (int i = 0; i < 20; i++) tick();
        sync_n = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        rst = 1'b1;
        tick();
        vectors++;
        if (act !== reset_vec) begin
            miscompares++;
            $display("FAIL reset_mid: dut=%h required=%h", act, reset_vec);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        vectors++;
        if (state !== 2'd1 || resync_cnt !== 8'd0 || act !== model_vec()) begin
            miscompares++;
            $display("FAIL reset_mid_after: dut=%h model=%h", act, model_vec());
        end
    endtask

    // Random SYNC~ runs, occasional disable and reset, against the model
    task automatic test_random();
        int run_left = 0;
        sync_n = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (run_left == 0) begin
                sync_n   = ~sync_n;
                run_left = sync_n ? int'($urandom_range(1, 80)) : int'($urandom_range(1, 34));
            end
            run_left--;
            rst     = ($urandom_range(0, 999) == 32'd0);
            link_en = ($urandom_range(0, 299) != 32'd0);
            tick();
            vectors++;
            if (act !== model_vec()) begin
                miscompares++;
                $display("FAIL random cyc%0d: dut=%h model=%h", i, act, model_vec());
            end
        end
        rst     = 1'b0;
        link_en = 1'b1;
    endtask

    // Resync counter saturation after 300 forced events
    task automatic test_saturate();
        do_reset();
        link_en = 1'b1;
        for (int e = 0; e < 301; e++) begin
            sync_n = 1'b1;
            for (int n = 0; n < 100 && state !== 2'd2; n++) tick();
            sync_n = 1'b0;
            for (int i = 0; i < 29; i++) tick();
            vectors++;
            if (state !== 2'd1 || act !== model_vec()) begin
                miscompares++;
                $display("FAIL saturate_event%0d: dut=%h model=%h", e, act, model_vec());
            end
            if (e == 299) begin
                vectors++;
                if (resync_cnt !== 8'd255) begin
                    miscompares++;
                    $display("FAIL saturate_300: dut=%0d required=255", resync_cnt);
                end
            end
        end
        vectors++;
        if (resync_cnt !== 8'd255) begin
            miscompares++;
            $display("FAIL saturate_hold: dut=%0d required=255", resync_cnt);
        end
    endtask

    initial begin
        rst     = 1'b1;
        link_en = 1'b0;
        sync_n  = 1'b1;
        test_reset();
        test_bringup();
        test_cgs_align();
        test_resync();
        test_link_drop();
        test_reset_mid();
        test_random();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
